muldiv_sequencer: RTL and testbench

//  Iterative multiply/divide sequencer that sits beside the EX stage ALU.
//  It accepts one MUL or DIV request per instruction and runs a shift-add

---
 rtl/muldiv_sequencer.sv | 178 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiplier / restoring divider that stalls the EX stage while it runs.
// Define MULDIV_SIGNED_EN for two's-complement operands (magnitude datapath plus sign fix-up).
module muldiv_sequencer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            mem_stall_i,
    input  logic            flush_i,
    input  logic            op_valid_i,
    input  logic            op_div_i,
    input  logic [XLEN-1:0] opa_i,
    input  logic [XLEN-1:0] opb_i,
    output logic [XLEN-1:0] result_lo_o,
    output logic [XLEN-1:0] result_hi_o,
    output logic            done_o,
    output logic            busy_o,
    output logic            ex_stall_o
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN);

    state_t            state;
    state_t            nextState;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   divisor;
    logic [XLEN-1:0]   resLo;
    logic [XLEN-1:0]   resHi;

    logic              accept;
    logic              cntDone;
    logic              divZero;
    logic [XLEN:0]     mulSum;
    logic [XLEN:0]     remShifted;
    logic [XLEN-1:0]   remSub;
    logic              quotBit;
    logic [2*XLEN-1:0] iterNext;
    logic [XLEN-1:0]   magA;
    logic [XLEN-1:0]   magB;
    logic [XLEN-1:0]   finLo;
    logic [XLEN-1:0]   finHi;
    logic [XLEN-1:0]   zeroRem;

`ifdef MULDIV_SIGNED_EN
    logic              negQ;
    logic              signA;
    logic [XLEN-1:0]   opaRaw;
    logic [2*XLEN-1:0] product;

    always_comb begin
        magA = opa_i[XLEN-1] ? -opa_i : opa_i;
        magB = opb_i[XLEN-1] ? -opb_i : opb_i;
    end

    // Sign fix-up is folded into the DONE-entry write so it costs no cycle.
    always_comb begin
        product = negQ ? -acc : acc;
        if (state == DIV) begin
            finLo = negQ  ? -acc[XLEN-1:0]      : acc[XLEN-1:0];
            finHi = signA ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        end else begin
            {finHi, finLo} = product;
        end
        zeroRem = opaRaw;
    end
`else
    always_comb begin
        magA           = opa_i;
        magB           = opb_i;
        {finHi, finLo} = acc;
        zeroRem        = acc[XLEN-1:0];
    end
`endif

    // acc holds {upper accumulator, multiplier} for MUL and {remainder, quotient} for DIV.
    always_comb begin
        accept     = op_valid_i & start_i & ~flush_i;
        cntDone    = (cnt == CNT_LAST);
        divZero    = (divisor == '0);
        mulSum     = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, divisor};
        remShifted = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        quotBit    = (remShifted >= {1'b0, divisor});
        remSub     = XLEN'(remShifted - {1'b0, divisor});
        iterNext   = '0;
        if (state == MUL) begin
            iterNext = acc[0] ? {mulSum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
        end else begin
            iterNext = {(quotBit ? remSub : remShifted[XLEN-1:0]), acc[XLEN-2:0], quotBit};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (accept) nextState = op_div_i ? DIV : MUL;
            MUL:  if (flush_i) nextState = IDLE;
                  else if (cntDone) nextState = DONE;
            DIV:  if (flush_i) nextState = IDLE;
                  else if (divZero || cntDone) nextState = DONE;
            DONE: if (flush_i || !mem_stall_i) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        done_o      = (state == DONE);
        busy_o      = (state != IDLE);
        ex_stall_o  = ((state == IDLE) & op_valid_i & start_i) | (state == MUL) | (state == DIV);
        result_lo_o = resLo;
        result_hi_o = resHi;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt     <= '0;
            acc     <= '0;
            divisor <= '0;
            resLo   <= '0;
            resHi   <= '0;
`ifdef MULDIV_SIGNED_EN
            negQ    <= 1'b0;
            signA   <= 1'b0;
            opaRaw  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc     <= {{XLEN{1'b0}}, magA};
                        divisor <= magB;
                        cnt     <= '0;
`ifdef MULDIV_SIGNED_EN
                        negQ    <= opa_i[XLEN-1] ^ opb_i[XLEN-1];
                        signA   <= opa_i[XLEN-1];
                        opaRaw  <= opa_i;
`endif
                    end
                end
                MUL, DIV: begin
                    if (flush_i) begin
                        resLo <= '0;
                        resHi <= '0;
                    end else if (state == DIV && divZero) begin
                        resLo <= '1;
                        resHi <= zeroRem;
                    end else if (cntDone) begin
                        resLo <= finLo;
                        resHi <= finHi;
                    end else begin
                        acc <= iterNext;
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (flush_i) begin
                        resLo <= '0;
                        resHi <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table plus scoreboard, and corner sequences.
// Signed vectors are selected when MULDIV_SIGNED_EN is defined.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        memStall = 1'b0;
    logic        flush = 1'b0;
    logic        opValid = 1'b0;
    logic        opDiv = 1'b0;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic [31:0] resultLo;
    logic [31:0] resultHi;
    logic        done;
    logic        busy;
    logic        exStall;

    typedef struct {
        logic        div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   nChecks = 0;
    int   nFails = 0;

    muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .mem_stall_i (memStall),
        .flush_i     (flush),
        .op_valid_i  (opValid),
        .op_div_i    (opDiv),
        .opa_i       (opa),
        .opb_i       (opb),
        .result_lo_o (resultLo),
        .result_hi_o (resultHi),
        .done_o      (done),
        .busy_o      (busy),
        .ex_stall_o  (exStall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called just after a negedge; returns just after a negedge with the unit back in IDLE.
    task automatic runOp(input string name, input logic div, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input int hold);
        int   cyc;
        logic stallOk;
        logic holdOk;
        logic neverDone;
        exp_t e;
        opDiv    = div;
        opa      = a;
        opb      = b;
        opValid  = 1'b1;
        start    = 1'b1;
        memStall = (hold > 0);
        #1 check($sformatf("%s.reqStall", name), 64'(exStall), 64'(1));
        @(posedge clk);
        #1 start = 1'b0;
        cyc     = 0;
        stallOk = 1'b1;
        forever begin
            @(negedge clk);
            if (done || cyc >= 100) break;
            if (!exStall || !busy) stallOk = 1'b0;
            @(posedge clk);
            cyc++;
        end
        check($sformatf("%s.latency", name), 64'(cyc), 64'(lat));
        check($sformatf("%s.stallBusy", name), 64'(stallOk), 64'(1));
        check($sformatf("%s.doneStall", name), 64'(exStall), 64'(0));
        if (sb.size() == 0) begin
            check($sformatf("%s.scoreboard", name), 64'(0), 64'(1));
            e = '{lo: '0, hi: '0};
        end else begin
            e = sb.pop_front();
        end
        check($sformatf("%s.lo", name), 64'(resultLo), 64'(e.lo));
        check($sformatf("%s.hi", name), 64'(resultHi), 64'(e.hi));
        if (hold > 0) begin
            holdOk = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                @(negedge clk);
                if (!done || resultLo !== e.lo || resultHi !== e.hi) holdOk = 1'b0;
            end
            check($sformatf("%s.memHold", name), 64'(holdOk), 64'(1));
        end
        memStall = 1'b0;
        opValid  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        neverDone = done | busy;
        check($sformatf("%s.backIdle", name), 64'(neverDone), 64'(0));
    endtask

    task automatic addVec(input logic div, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lo, input logic [31:0] hi, input int lat);
        vec_t v;
        v.div = div; v.a = a; v.b = b; v.lo = lo; v.hi = hi; v.lat = lat;
        vecs.push_back(v);
    endtask

    initial begin
        logic        neverDone;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] p;
        logic [31:0] q;
        logic [31:0] r;

        addVec(1'b0, 32'd7,         32'd6,         32'h0000002A, 32'h0,        33);
        addVec(1'b1, 32'd100,       32'd7,         32'd14,       32'd2,        33);
        addVec(1'b1, 32'd5,         32'd0,         32'hFFFFFFFF, 32'd5,        1);
        addVec(1'b0, 32'h00010000,  32'h00010000,  32'h0,        32'h1,        33);
        addVec(1'b1, 32'd7,         32'd100,       32'h0,        32'd7,        33);
        addVec(1'b1, 32'd0,         32'd0,         32'hFFFFFFFF, 32'h0,        1);
        addVec(1'b0, 32'd0,         32'h12345678,  32'h0,        32'h0,        33);
`ifdef MULDIV_SIGNED_EN
        addVec(1'b0, 32'hFFFFFFFA,  32'd7,         32'hFFFFFFD6, 32'hFFFFFFFF, 33);
        addVec(1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD, 32'hFFFFFFFF, 33);
        addVec(1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000, 32'h0,        33);
        addVec(1'b1, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFF, 32'hFFFFFFFB, 1);
        addVec(1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h1,        32'h0,        33);
`else
        addVec(1'b1, 32'hFFFFFFFF,  32'h10,        32'h0FFFFFFF, 32'hF,        33);
        addVec(1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001, 32'hFFFFFFFE, 33);
        addVec(1'b0, 32'hFFFFFFFA,  32'd7,         32'hFFFFFFD6, 32'h6,        33);
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.flags", {61'(0), done, busy, exStall}, 64'(0));
        check("reset.result", {resultHi, resultLo}, 64'(0));
        rst = 1'b0;

        opValid = 1'b1;
        start   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("noStart.busy", {62'(0), busy, exStall}, 64'(0));
        opValid = 1'b0;

        foreach (vecs[i]) begin
            sb.push_back('{lo: vecs[i].lo, hi: vecs[i].hi});
            runOp($sformatf("vec%0d", i), vecs[i].div, vecs[i].a, vecs[i].b, vecs[i].lat, 0);
        end

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom | 32'h1;
            if (rb == 32'hFFFFFFFF) rb = 32'd3;
`ifdef MULDIV_SIGNED_EN
            p = 64'(longint'($signed(ra)) * longint'($signed(rb)));
            q = 32'(longint'($signed(ra)) / longint'($signed(rb)));
            r = 32'(longint'($signed(ra)) % longint'($signed(rb)));
`else
            p = {32'h0, ra} * {32'h0, rb};
            q = ra / rb;
            r = ra % rb;
`endif
            if (i[0]) sb.push_back('{lo: q, hi: r});
            else      sb.push_back('{lo: p[31:0], hi: p[63:32]});
            runOp($sformatf("rand%0d", i), i[0], ra, rb, 33, 0);
        end

        sb.push_back('{lo: 32'd42, hi: 32'd0});
        runOp("memStall", 1'b0, 32'd7, 32'd6, 33, 4);

        // Flush 10 cycles into a MUL while the previous result (42) is still on the outputs.
        opDiv = 1'b0; opa = 32'd3; opb = 32'd5; opValid = 1'b1; start = 1'b1;
        @(posedge clk);
        neverDone = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (done) neverDone = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check("flush.neverDone", 64'(neverDone), 64'(1));
        check("flush.flags", {62'(0), done, busy}, 64'(0));
        check("flush.result", {resultHi, resultLo}, 64'(0));
        sb.push_back('{lo: 32'd99, hi: 32'd0});
        runOp("postFlush", 1'b0, 32'd9, 32'd11, 33, 0);

        opDiv = 1'b1; opa = 32'd100; opb = 32'd7; opValid = 1'b1; start = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        opValid = 1'b0;
        start   = 1'b0;
        rst     = 1'b1;
        #1;
        check("midReset.flags", {61'(0), done, busy, exStall}, 64'(0));
        check("midReset.result", {resultHi, resultLo}, 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        sb.push_back('{lo: 32'd14, hi: 32'd2});
        runOp("afterReset", 1'b1, 32'd100, 32'd7, 33, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
